serial_adder: RTL and testbench

Parametrised multi-cycle adder built on a single adder slice. It replaces the combinational half/full adders for wide operands where area matters more than latency. Each clock it processes BITS_PER_CYCLE bits, LSB first, under a start/busy/done handshake. It sits as a datapath leaf beside the existing adder blocks.

---
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder built on one BITS_PER_CYCLE-wide adder slice.
// Operands are consumed LSB first, one slice per clock, under a start/busy/done
// handshake. {c_out, sum} = din_a + din_b + c_in, modulo 2^(WIDTH+1).
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input (A - B) and an `ovf`
// output flagging signed two's-complement overflow of the effective operation.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int NumSlices = WIDTH / BITS_PER_CYCLE;
  localparam int CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  typedef enum logic {
    StIdle,
    StRun
  } state_t;

  state_t                  state;
  logic [WIDTH-1:0]        a_sr;
  logic [WIDTH-1:0]        b_sr;
  logic                    carry;
  logic [WIDTH-1:0]        psum;
  logic [CntW-1:0]         cnt;

  logic [BITS_PER_CYCLE:0] slice;
  logic [WIDTH-1:0]        psum_next;
  logic                    last;
  logic [WIDTH-1:0]        b_cap;
  logic                    c_cap;

`ifdef SERIAL_ADDER_SUB_EN
  // MSBs of the effective operands, kept for the overflow flag after shifting
  logic                    a_msb;
  logic                    b_msb;
`endif

  // Slice adder, end-of-operation detect and operand preparation at capture
  always_comb begin
    slice = {1'b0, a_sr[BITS_PER_CYCLE-1:0]} + {1'b0, b_sr[BITS_PER_CYCLE-1:0]}
          + {{BITS_PER_CYCLE{1'b0}}, carry};
    last  = (cnt == CntW'(NumSlices - 1));
`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1
    b_cap = sub ? ~din_b : din_b;
    c_cap = sub ? 1'b1 : c_in;
`else
    b_cap = din_b;
    c_cap = c_in;
`endif
  end

  // New slice enters at the top; after NumSlices shifts the sum is aligned
  if (NumSlices > 1) begin : g_shift
    assign psum_next = {slice[BITS_PER_CYCLE-1:0], psum[WIDTH-1:BITS_PER_CYCLE]};
  end else begin : g_single
    assign psum_next = slice[BITS_PER_CYCLE-1:0];
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      psum  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= din_a;
            b_sr  <= b_cap;
            carry <= c_cap;
            psum  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
`ifdef SERIAL_ADDER_SUB_EN
            a_msb <= din_a[WIDTH-1];
            b_msb <= b_cap[WIDTH-1];
`endif
          end
        end
        StRun: begin
          a_sr  <= a_sr >> BITS_PER_CYCLE;
          b_sr  <= b_sr >> BITS_PER_CYCLE;
          carry <= slice[BITS_PER_CYCLE];
          psum  <= psum_next;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= psum_next;
            c_out <= slice[BITS_PER_CYCLE];
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= StIdle;
`ifdef SERIAL_ADDER_SUB_EN
            ovf   <= (a_msb == b_msb) && (psum_next[WIDTH-1] != a_msb);
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at BITS_PER_CYCLE
// 1 and 4 against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st1, st4;
  logic [7:0] a_in, b_in;
  logic       ci;
  logic       busy1, done1, cout1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4;
  logic [7:0] sum4;
  logic [7:0] prev1, prev4;
  int         errors = 0;
  int         checks = 0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub_in;
  logic       ovf1, ovf4;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .din_a(a_in), .din_b(b_in), .c_in(ci),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub_in), .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .din_a(a_in), .din_b(b_in), .c_in(ci),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub_in), .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {borrow-free flag or carry, 8-bit result} from plain arithmetic
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    if (s) return {(a >= b), 8'(a - b)};
    else   return 9'(a) + 9'(b) + 9'(c);
  endfunction

`ifdef SERIAL_ADDER_SUB_EN
  function automatic logic ovf_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic c, input logic s);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = s ? (sa - sb) : (sa + sb + int'(c));
    return (r > 127) || (r < -128);
  endfunction
`endif

  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done4;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy4;
  endfunction
  function automatic logic [7:0] get_sum(input int sel);
    return (sel == 1) ? sum1 : sum4;
  endfunction
  function automatic logic get_cout(input int sel);
    return (sel == 1) ? cout1 : cout4;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic start_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s);
    a_in = a;
    b_in = b;
    ci   = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = s;
`endif
    if (sel == 1) st1 = 1'b1;
    else          st4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st1  = 1'b0;
    st4  = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    ci   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = 1'($urandom);
`endif
    check("busy_after_start", 32'(get_busy(sel)), 32'd1);
  endtask

  // Waits for done, checking latency, busy length, sum hold and the result
  task automatic wait_done(input int sel, input int exp_lat, input logic [7:0] a,
                           input logic [7:0] b, input logic c, input logic s,
                           input int pulse_at, input string tag);
    int         lat      = -1;
    int         busy_cnt = 1;
    int         hold_err = 0;
    logic [8:0] e;
    logic [7:0] prev;
    e    = model(a, b, c, s);
    prev = (sel == 1) ? prev1 : prev4;
    for (int i = 1; i <= 40; i++) begin
      if (sel == 1 && i == pulse_at) begin
        st1  = 1'b1;
        a_in = 8'hFF;
      end else begin
        st1 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (get_done(sel)) begin
        lat = i;
        break;
      end
      if (get_busy(sel)) busy_cnt++;
      if (get_sum(sel) !== prev) hold_err++;
    end
    st1 = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_sum_hold"}, 32'(hold_err), 32'd0);
    check({tag, "_sum"}, 32'(get_sum(sel)), 32'(e[7:0]));
    check({tag, "_c_out"}, 32'(get_cout(sel)), 32'(e[8]));
    check({tag, "_busy_low"}, 32'(get_busy(sel)), 32'd0);
`ifdef SERIAL_ADDER_SUB_EN
    check({tag, "_ovf"}, 32'((sel == 1) ? ovf1 : ovf4), 32'(ovf_model(a, b, c, s)));
`endif
    if (sel == 1) prev1 = e[7:0];
    else          prev4 = e[7:0];
  endtask

  // Counts done pulses of dut1 over a window of cycles
  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) n++;
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         n;
    rst   = 1'b1;
    st1   = 1'b0;
    st4   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    ci    = 1'b0;
    prev1 = '0;
    prev4 = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = 1'b0;
`endif
    #12;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_sum", 32'(sum1), 32'd0);
    check("rst_c_out", 32'(cout1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(3, n);
    check("idle_no_done", 32'(n), 32'd0);
    check("idle_busy", 32'(busy1), 32'd0);

    // 0xFF + 0x01 wraps with carry out
    start_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(1, 8, 8'hFF, 8'h01, 1'b0, 1'b0, 0, "ff_plus_1");
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 32'(done1), 32'd0);
    check("sum_held_idle", 32'(sum1), 32'h00);

    // Back-to-back start accepted on the done cycle
    start_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_done(1, 8, 8'hA5, 8'h5A, 1'b1, 1'b0, 0, "a5_5a_ci");
    start_op(1, 8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(1, 8, 8'h12, 8'h34, 1'b0, 1'b0, 0, "back_to_back");

    // Start while busy is ignored
    @(posedge clk);
    @(negedge clk);
    start_op(1, 8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(1, 8, 8'h01, 8'h01, 1'b0, 1'b0, 3, "ignore_start");
    count_dones(15, n);
    check("single_done", 32'(n), 32'd0);

    // Asynchronous reset in the middle of a run
    start_op(1, 8'hC3, 8'h77, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_sum", 32'(sum1), 32'd0);
    check("midrst_c_out", 32'(cout1), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    prev1 = '0;
    prev4 = '0;
    count_dones(15, n);
    check("midrst_no_done", 32'(n), 32'd0);
    start_op(1, 8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(1, 8, 8'h10, 8'h20, 1'b0, 1'b0, 0, "after_rst");

    // Four bits per cycle
    @(negedge clk);
    start_op(4, 8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done(4, 2, 8'h3C, 8'h0F, 1'b0, 1'b0, 0, "bpc4");

`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    start_op(1, 8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(1, 8, 8'h05, 8'h07, 1'b0, 1'b1, 0, "sub_5_7");
    @(negedge clk);
    start_op(1, 8'h80, 8'h01, 1'b1, 1'b1);
    wait_done(1, 8, 8'h80, 8'h01, 1'b1, 1'b1, 0, "sub_80_1");
`endif

    // Random operations on both configurations
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      @(negedge clk);
      start_op(1, ra, rb, rc, rs);
      wait_done(1, 8, ra, rb, rc, rs, 0, "rand_bpc1");
      start_op(4, ra, rb, rc, rs);
      wait_done(4, 2, ra, rb, rc, rs, 0, "rand_bpc4");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
